// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, coin values and FSM states for the change-payout sequencer
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_N = 2'd0,
    COIN_D = 2'd1,
    COIN_Q = 2'd2
  } coin_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int VAL_N = 5;
  localparam int VAL_D = 10;
  localparam int VAL_Q = 25;

endpackage

// File: rtl/vend_change_ctrl_if.sv
// rtl/vend_change_ctrl_if.sv - change request and coin-eject handshakes
interface vend_change_ctrl_if #(
  parameter int AMT_W = 8
);
  import vend_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             eject_valid;
  coin_e            eject_coin;
  logic             eject_ack;

  modport master (
    output req_valid, req_amount, eject_ack,
    input  req_ready, eject_valid, eject_coin
  );

  modport slave (
    input  req_valid, req_amount, eject_ack,
    output req_ready, eject_valid, eject_coin
  );

endinterface

// File: rtl/vend_coin_inv.sv
// rtl/vend_coin_inv.sv - one denomination's coin counter: saturating refill plus single-coin decrement
module vend_coin_inv #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_valid,
  input  logic [CNT_W-1:0] add_count,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sat;
  logic [CNT_W-1:0] count_nxt;

  // Saturate the refill first, then take the ejected coin out of the saturated value.
  always_comb begin
    sum       = {1'b0, count} + (add_valid ? {1'b0, add_count} : '0);
    sat       = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    count_nxt = (dec && (sat != '0)) ? sat - CNT_W'(1) : sat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vend_change_ctrl.sv
// rtl/vend_change_ctrl.sv - greedy change payout, one coin-eject command at a time
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  vend_change_ctrl_if.slave  bus,
  input  logic               refill_valid,
  input  logic [1:0]         refill_coin,
  input  logic [CNT_W-1:0]   refill_count,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remaining,
  output logic [CNT_W-1:0]   inv_q,
  output logic [CNT_W-1:0]   inv_d,
  output logic [CNT_W-1:0]   inv_n
);

  localparam logic [AMT_W-1:0] AV_N = AMT_W'(VAL_N);
  localparam logic [AMT_W-1:0] AV_D = AMT_W'(VAL_D);
  localparam logic [AMT_W-1:0] AV_Q = AMT_W'(VAL_Q);

  state_e           state;
  state_e           state_nxt;
  coin_e            coin_r;
  coin_e            sel_coin;
  logic             sel_found;
  logic             short_r;
  logic [AMT_W-1:0] rem_r;
  logic             ack_hs;

  function automatic logic [AMT_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_Q:  return AV_Q;
      COIN_D:  return AV_D;
      default: return AV_N;
    endcase
  endfunction

  // Largest coin that fits and is in stock; the selector only sees registered inventory.
  always_comb begin
    sel_found = 1'b1;
    sel_coin  = COIN_N;
    if ((rem_r >= AV_Q) && (inv_q != '0)) begin
      sel_coin = COIN_Q;
    end else if ((rem_r >= AV_D) && (inv_d != '0)) begin
      sel_coin = COIN_D;
    end else if ((rem_r >= AV_N) && (inv_n != '0)) begin
      sel_coin = COIN_N;
    end else begin
      sel_found = 1'b0;
    end
  end

  assign ack_hs = (state == EJECT) && bus.eject_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = SELECT;
      SELECT:  state_nxt = sel_found ? EJECT : DONE;
      EJECT:   if (bus.eject_ack) state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.eject_valid = (state == EJECT);
    bus.eject_coin  = coin_r;
    done            = (state == DONE);
    short           = short_r;
    remaining       = rem_r;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_r   <= '0;
      short_r <= 1'b0;
      coin_r  <= COIN_N;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rem_r   <= bus.req_amount;
            short_r <= 1'b0;
          end
        end
        SELECT: begin
          if (sel_found) begin
            coin_r <= sel_coin;
          end else begin
            short_r <= (rem_r != '0);
          end
        end
        EJECT: begin
          if (bus.eject_ack) begin
            rem_r <= rem_r - coin_value(coin_r);
          end
        end
        default: ;
      endcase
    end
  end

  vend_coin_inv #(.CNT_W(CNT_W)) u_inv_q (
    .clk       (clk),
    .rst       (rst),
    .add_valid (refill_valid && (refill_coin == COIN_Q)),
    .add_count (refill_count),
    .dec       (ack_hs && (coin_r == COIN_Q)),
    .count     (inv_q)
  );

  vend_coin_inv #(.CNT_W(CNT_W)) u_inv_d (
    .clk       (clk),
    .rst       (rst),
    .add_valid (refill_valid && (refill_coin == COIN_D)),
    .add_count (refill_count),
    .dec       (ack_hs && (coin_r == COIN_D)),
    .count     (inv_d)
  );

  vend_coin_inv #(.CNT_W(CNT_W)) u_inv_n (
    .clk       (clk),
    .rst       (rst),
    .add_valid (refill_valid && (refill_coin == COIN_N)),
    .add_count (refill_count),
    .dec       (ack_hs && (coin_r == COIN_N)),
    .count     (inv_n)
  );

endmodule
